// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional abort input is enabled by defining MUL_DIV_CANCEL_EN.
module mul_div_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MUL_DIV_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam logic [3:0] MultCycles = 4'd4;
    localparam logic [3:0] DivCycles  = 4'd9;

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic        latch;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] shadow_hi_q, shadow_lo_q;
    logic        shadow_wr_q;
    logic        cancel;

`ifdef MUL_DIV_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    // Arithmetic datapath, fed only from the latched operands
    logic        is_signed, is_div;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, quot_mag, rem_mag, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];

    always_comb begin
        a_ext    = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext    = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        // Low 64 bits of the extended product are correct for both signednesses
        prod     = a_ext * b_ext;
        a_neg    = is_signed & a_q[31];
        b_neg    = is_signed & b_q[31];
        a_mag    = a_neg ? 32'd0 - a_q : a_q;
        b_mag    = b_neg ? 32'd0 - b_q : b_q;
        div_zero = (b_q == 32'd0);
        quot_mag = div_zero ? 32'd0 : a_mag / b_mag;
        rem_mag  = div_zero ? 32'd0 : a_mag % b_mag;
        quot     = (a_neg ^ b_neg) ? 32'd0 - quot_mag : quot_mag;
        rem      = a_neg ? 32'd0 - rem_mag : rem_mag;
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = ~div_zero;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (Start && !cancel) begin
                    case (Op)
                        OpMult, OpMultu: begin
                            latch   = 1'b1;
                            cnt_d   = MultCycles;
                            state_d = StRun;
                        end
                        OpDiv, OpDivu: begin
                            latch   = 1'b1;
                            cnt_d   = DivCycles;
                            state_d = StRun;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cancel) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    if (shadow_wr_q) begin
                        hi_d = shadow_hi_q;
                        lo_d = shadow_lo_q;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 2'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            shadow_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (latch) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= Op[1:0];
            end
            // Shadow is refreshed every RUN cycle; it is settled well before Cnt reaches 0
            if (state_q == StRun) begin
                shadow_hi_q <= res_hi;
                shadow_lo_q <= res_lo;
                shadow_wr_q <= res_wr;
            end
        end
    end

    assign Busy = (state_q == StRun);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
